wide_add_sequencer: RTL

- Performs multi-precision add/subtract of 16*WORDS-bit operands.
- Time-multiplexes one instance of carry_look_ahead_adder_2level_16b, one 16-bit word per cycle, LSW first, chaining carry through a register.
- Sits between the ALU issue logic and the shared 16-bit adder; start/busy/done handshake toward the issuer.

---
 rtl/wide_add_sequencer_if.sv | 28 ++
 rtl/wide_add_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer_if.sv
// Issuer <-> wide add sequencer handshake and operand/result bus.
interface wide_add_sequencer_if #(
  parameter int WORDS = 4
);
  localparam int W = 16 * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  // Issuer side
  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  // Sequencer side
  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract: one 16-bit CLA reused per word, LSW first,
// carry chained through a register. Contains the shared 16-bit adder.

// 16-bit two-level carry-lookahead adder: 4-bit groups, group P/G combined
// by a second lookahead level.
module carry_look_ahead_adder_2level_16b (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_p, w_g, w_c;
  logic [3:0]  w_gp, w_gg;
  logic [4:0]  w_gc;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;
    // group propagate / generate
    assign w_gp[k] = &w_p[B+3:B];
    assign w_gg[k] = w_g[B+3]
                   | (w_p[B+3] & w_g[B+2])
                   | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                   | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    // bit carries inside the group from the group carry-in
    assign w_c[B]   = w_gc[k];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                    | (w_p[B+1] & w_p[B] & w_gc[k]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                    | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
  end

  // second-level lookahead across groups
  assign w_gc[0] = i_cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[4];
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wide_add_sequencer_if.slave  bus
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  r_state, w_next;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_carry;
  logic [WORDS-1:0][15:0]  r_opa, r_opb, r_work, r_result;
  logic                    r_cout, r_ovf;

  logic [15:0]             w_wa, w_wb, w_sum;
  logic                    w_cout, w_last, w_busy, w_done;
  logic [WORDS-1:0][15:0]  w_final;

  assign w_last = (r_idx == IDX_W'(WORDS - 1));

  // select the current operand words (mux avoids variable part-selects)
  always_comb begin
    w_wa = '0;
    w_wb = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_wa = r_opa[k];
        w_wb = r_opb[k];
      end
    end
  end

  carry_look_ahead_adder_2level_16b u_cla (
    .i_a    (w_wa),
    .i_b    (w_wb),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // completed word image: lower words from r_work, top word straight from the adder
  always_comb begin
    w_final            = r_work;
    w_final[WORDS-1]   = w_sum;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // next state and handshake outputs
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_next = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // operand latch, word iteration, and result commit on the last word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_work   <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            // subtract as a + ~b + 1: invert B here, inject the +1 as carry-in
            r_opa   <= bus.a;
            r_opb   <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
            r_idx   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++)
            if (r_idx == IDX_W'(k)) r_work[k] <= w_sum;
          r_carry <= w_cout;
          if (w_last) begin
            r_result <= w_final;
            r_cout   <= w_cout;
            r_ovf    <= (r_opa[WORDS-1][15] == r_opb[WORDS-1][15]) &&
                        (w_sum[15] != r_opa[WORDS-1][15]);
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
endmodule
